// File: rtl/add_serial_arb.sv
// -----------------------------------------------------------------------------
// add_serial_arb
//
// Round-robin arbiter plus sequencer that shares a single bit-serial full
// adder among NREQ requesters. One requester is granted at a time. Its
// operands are shifted LSB-first through the adder over WIDTH cycles, and
// the result is then presented on a valid/ready response port.
//
// Ports
//   clk        : clock, all state on posedge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ]        per-requester request valid
//   req_ready  : [NREQ]        per-requester accept (at most one bit high)
//   req_a      : [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      : [NREQ*WIDTH]  operand B, same packing
//   rsp_valid  : response valid
//   rsp_ready  : response accept
//   rsp_id     : [IDW]   requester the response belongs to
//   rsp_sum    : [WIDTH] (a+b) mod 2^WIDTH
//   rsp_cout   : carry out of bit WIDTH-1
//   busy       : high whenever the engine is not idle
// -----------------------------------------------------------------------------
module add_serial_arb #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [WIDTH-1:0]        rsp_sum,
   output logic                    rsp_cout,
   output logic                    busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    count_q, count_d;

   logic [IDW-1:0]   grant;
   logic             any_valid;
   logic             sum_bit;

   // Round-robin pick: scan downward from the farthest candidate so the
   // nearest valid requester after last_grant_q is the one that sticks.
   always_comb begin
      int idx;
      grant = last_grant_q;
      idx   = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last_grant_q) + k) % NREQ;
         if (req_valid[idx]) grant = IDW'(idx);
      end
   end

   assign any_valid = |req_valid;

   // Ready looks only at state and req_valid, never at operands or rsp_ready.
   assign req_ready = (state_q == IDLE && any_valid) ? (NREQ'(1) << grant) : '0;

   // NOTE: every *_d gets a default equal to its *_q before the case, so no
   // path through the case can leave a variable unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      sum_d        = sum_q;
      carry_d      = carry_q;
      cout_d       = cout_q;
      count_d      = count_q;
      sum_bit      = 1'b0;

      case (state_q)
         IDLE: begin
            // The grantee is always ready when anyone is valid, so any_valid
            // is the handshake condition.
            if (any_valid) begin
               a_d     = req_a[int'(grant)*WIDTH +: WIDTH];
               b_d     = req_b[int'(grant)*WIDTH +: WIDTH];
               carry_d = 1'b0;
               count_d = '0;
               id_d    = grant;
               state_d = ADD;
            end
         end

         ADD: begin
            sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
            carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH-1)) begin
               cout_d  = carry_d;
               state_d = RESP;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               last_grant_d = id_q;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NREQ-1);
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         carry_q      <= 1'b0;
         cout_q       <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sum_q        <= sum_d;
         carry_q      <= carry_d;
         cout_q       <= cout_d;
         count_q      <= count_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_add_serial_arb.sv
module tb_add_serial_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = $clog2(NREQ);

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  busy;

   add_serial_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: transaction level. Tracks whether an operation is in
   // flight, when it was accepted, and its expected result a+b. The response
   // is due WIDTH edges after the accept edge.
   // ---------------------------------------------------------------------
   int               cyc        = 0;
   bit               m_inflight = 0;
   int               m_acc      = 0;
   int               m_id       = 0;
   int               m_last     = NREQ-1;
   logic [WIDTH:0]   m_res      = '0;
   int               n_ops      = 0;
   int               wait_ops[NREQ];
   int               acc_ids[$];
   int               acc_cycs[$];

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         m_inflight = 0;
         m_last     = NREQ-1;
         for (int i = 0; i < NREQ; i++) wait_ops[i] = 0;
      end else begin
         cyc++;
         check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
         if (!m_inflight) begin
            int g;
            logic [NREQ-1:0] exp_rdy;
            g       = rr_pick(req_valid, m_last);
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            check("req_ready_idle", 64'(req_ready), 64'(exp_rdy));
            check("busy_idle", 64'(busy), 64'(0));
            check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            if (g >= 0) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (req_valid[i] && i != g) begin
                     wait_ops[i]++;
                     check("no_starvation", 64'(wait_ops[i] < NREQ), 64'(1));
                  end else begin
                     wait_ops[i] = 0;
                  end
               end
               m_inflight = 1;
               m_acc      = cyc;
               m_id       = g;
               m_res      = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]};
               acc_ids.push_back(g);
               acc_cycs.push_back(cyc);
               n_ops++;
            end
         end else begin
            check("req_ready_busy", 64'(req_ready), 64'(0));
            check("busy_active", 64'(busy), 64'(1));
            if (cyc - m_acc > WIDTH) begin
               check("rsp_valid_due", 64'(rsp_valid), 64'(1));
               check("rsp_sum", 64'(rsp_sum), 64'(m_res[WIDTH-1:0]));
               check("rsp_cout", 64'(rsp_cout), 64'(m_res[WIDTH]));
               check("rsp_id", 64'(rsp_id), 64'(m_id));
               if (rsp_ready) begin
                  m_inflight = 0;
                  m_last     = m_id;
               end
            end else begin
               check("rsp_valid_early", 64'(rsp_valid), 64'(0));
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed helpers
   // ---------------------------------------------------------------------
   task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_valid[id]             = 1'b1;
      req_a[id*WIDTH +: WIDTH]  = a;
      req_b[id*WIDTH +: WIDTH]  = b;
   endtask

   task automatic wait_accept(input int id);
      bit got = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (req_ready[id]) begin got = 1; break; end
      end
      check("accept_timeout", 64'(got), 64'(1));
   endtask

   task automatic wait_idle();
      bit got = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!busy) begin got = 1; break; end
      end
      check("idle_timeout", 64'(got), 64'(1));
   endtask

   task automatic do_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
      int lat;
      bit got;
      @(posedge clk); #1;
      set_req(id, a, b);
      wait_accept(id);
      @(posedge clk); #1;               // accept edge E has passed
      req_valid[id] = 1'b0;
      lat = 0;
      got = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (rsp_valid) begin got = 1; break; end
         @(posedge clk);
         lat++;
      end
      check("rsp_timeout", 64'(got), 64'(1));
      check("latency", 64'(lat), 64'(WIDTH));
      check("op_sum", 64'(rsp_sum), 64'(exp_sum));
      check("op_cout", 64'(rsp_cout), 64'(exp_cout));
      check("op_id", 64'(rsp_id), 64'(id));
      @(posedge clk);                   // response handshake
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      logic [NREQ-1:0] rdy_s;
      int              n_start;
      int              exp_order[6];
      bit              got;

      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      #3;
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_rsp_sum", 64'(rsp_sum), 64'(0));
      check("rst_rsp_id", 64'(rsp_id), 64'(0));
      check("rst_rsp_cout", 64'(rsp_cout), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single op and overflow cases
      do_op(0, 8'h5A, 8'h3C, 8'h96, 1'b0);
      do_op(2, 8'hFF, 8'h01, 8'h00, 1'b1);
      do_op(2, 8'hFF, 8'hFF, 8'hFE, 1'b1);
      do_op(3, 8'h80, 8'h7F, 8'hFF, 1'b0);

      // Backpressure: hold response for 5 cycles while another requester waits
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_req(1, 8'h12, 8'h34);
      wait_accept(1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      got = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (rsp_valid) begin got = 1; break; end
      end
      check("bp_rsp_timeout", 64'(got), 64'(1));
      @(posedge clk); #1;
      set_req(3, 8'h80, 8'h80);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("bp_valid", 64'(rsp_valid), 64'(1));
         check("bp_sum", 64'(rsp_sum), 64'(8'h46));
         check("bp_id", 64'(rsp_id), 64'(1));
         check("bp_cout", 64'(rsp_cout), 64'(0));
         check("bp_busy", 64'(busy), 64'(1));
         check("bp_req_ready", 64'(req_ready), 64'(0));
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);                   // handshake edge still ahead
      check("bp_hold_valid", 64'(rsp_valid), 64'(1));
      @(negedge clk);                   // one edge after handshake: IDLE
      check("bp_idle_busy", 64'(busy), 64'(0));
      check("bp_idle_valid", 64'(rsp_valid), 64'(0));
      check("bp_idle_ready", 64'(req_ready), 64'(4'b1000));
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      @(negedge clk);
      check("bp_next_sum_busy", 64'(busy), 64'(1));
      wait_idle();

      // Fairness: all valid from reset
      @(posedge clk); #1;
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(8'h10 * i + 1), WIDTH'(8'h21 + i));
      @(negedge clk);
      acc_ids.delete();
      acc_cycs.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      got = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (acc_ids.size() >= 6) begin got = 1; break; end
      end
      check("fair_timeout", 64'(got), 64'(1));
      exp_order = '{0, 1, 2, 3, 0, 1};
      if (acc_ids.size() >= 6) begin
         for (int i = 0; i < 6; i++) check("fair_order", 64'(acc_ids[i]), 64'(exp_order[i]));
         for (int i = 0; i < 5; i++) check("fair_gap", 64'(acc_cycs[i+1] - acc_cycs[i]), 64'(WIDTH + 2));
      end

      // Reset in the middle of an operation
      @(posedge clk); #1;
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 8'h11, 8'h22);
      wait_accept(0);
      @(posedge clk); #1;               // edge E
      req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;                               // inside the 4th ADD cycle
      check("mid_busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
      check("mid_busy", 64'(busy), 64'(0));
      check("mid_rsp_sum", 64'(rsp_sum), 64'(0));
      check("mid_rsp_id", 64'(rsp_id), 64'(0));
      check("mid_rsp_cout", 64'(rsp_cout), 64'(0));
      set_req(1, 8'h01, 8'h02);
      set_req(0, 8'h03, 8'h04);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_first_grant", 64'(req_ready), 64'(4'b0001));

      // Random: 1000 operations with random valids, operands and stalls
      n_start = n_ops;
      for (int n = 0; n < 60000 && (n_ops - n_start) < 1000; n++) begin
         if (n != 0) @(negedge clk);
         rdy_s = req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && rdy_s[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) set_req(i, WIDTH'($urandom), WIDTH'($urandom));
            end else if ($urandom_range(0, 49) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      check("random_ops_done", 64'((n_ops - n_start) >= 1000), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/add_serial_arb.md
# add_serial_arb

Round-robin arbiter and sequencer that shares one bit-serial adder engine among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time and shifts the operands LSB-first through a single full adder over WIDTH cycles. It then returns the sum, carry-out and requester id on a response valid/ready port. It sits between the control-path clients and the serial arithmetic datapath and is the only place where adder ownership is decided.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand and sum width in bits, 2..32.
- IDW, $clog2(NREQ): width of the requester id (derived; do not override).
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester this response belongs to.
- rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ADD, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching upward from (last_grant+1) mod NREQ and wrapping.
  - req_ready[grant]=1 combinationally. This requires any req_valid=1; all other ready bits are 0.
  - On valid&ready: capture req_a/req_b of the grantee into shift registers, clear carry, clear count, latch grant id, then go to ADD.
- ADD, one bit per cycle:
  - sum_bit = a0^b0^carry.
  - carry <= majority(a0, b0, carry).
  - a and b shift right by 1.
  - sum register shifts right with sum_bit entering at the MSB.
  - count increments.
  - When count==WIDTH-1: go to RESP, and register the final carry into rsp_cout.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_cout are held stable.
  - On rsp_valid&rsp_ready: last_grant <= rsp_id, then go to IDLE.
  - Without rsp_ready, remain in RESP indefinitely.
- req_ready is all-zero in ADD and RESP. Requests arriving then stay pending; requesters must hold req_valid and data until accepted.
- Deasserting req_valid before acceptance is legal and has no effect.
- Reset values:
  - state=IDLE.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
  - Shift registers, carry and count are 0.
- rst_n low mid-operation: all state clears immediately (asynchronously). The in-flight operation is discarded and no response is produced.

## Timing
- Accept edge E: the edge where req_valid&req_ready. ADD occupies the WIDTH cycles after E.
- rsp_valid rises exactly WIDTH cycles after E and is registered (no combinational path from inputs).
- req_ready depends combinationally on req_valid and state only. It never depends on req_a/req_b or rsp_ready.
- Response accept edge R: IDLE holds for the cycle after R. The next accept is earliest one edge after that.
- With rsp_ready tied high, peak throughput is one operation per WIDTH+2 cycles.
- Simultaneous requests: exactly one grant. Round-robin guarantees each continuously-valid requester is served within NREQ operations.
- A requester that becomes valid in the same cycle another is granted waits for the next arbitration round.

## Test plan
- Single op: req 0, a=8'h5A, b=8'h3C, rsp_ready=1 -> rsp_valid exactly 8 cycles after accept, with rsp_sum=8'h96, rsp_cout=0, rsp_id=0.
- Overflow: req 2, a=8'hFF, b=8'h01 -> rsp_sum=8'h00, rsp_cout=1, rsp_id=2. Also a=8'hFF, b=8'hFF -> rsp_sum=8'hFE, rsp_cout=1.
- Fairness: all four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1. Consecutive accepts are 10 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_sum and rsp_id stable; req_ready=0; busy=1. After rsp_ready=1 there is one handshake, and IDLE follows on the next edge.
- Reset mid-op: drop rst_n in the 4th ADD cycle -> rsp_valid=0, busy=0 and outputs zero with no clock. After release, requesters 1 and 0 both valid -> requester 0 is granted first.
- Random: 1000 ops with random valids, operands and rsp_ready stalls, checked against a+b -> no mismatch, never more than one req_ready bit high, no starvation beyond NREQ operations.
